regfile_port_sequencer: RTL and testbench
=========================================

Name: regfile_port_sequencer

Overview:
- Client-side controller for the single-port register file, the initiator that issues writes and reads through its one shared i_we/i_addr/i_data port.
- Serialises decode-stage operand reads (rs1, rs2) and write-back writes onto that port and returns both operands through a valid/ready handshake.
- Sits between decode/write-back and the register file in the RV32I core.

Parameters:
ADDR_WIDTH, 5, register index width (32 registers)
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  operand read request
req_ready  out  1  request accepted on this edge when req_valid is also high
req_rs1  in  ADDR_WIDTH  first source index
req_rs2  in  ADDR_WIDTH  second source index
rsp_valid  out  1  operands available
rsp_ready  in  1  consumer takes operands
rsp_rs1_data  out  DATA_WIDTH  value of x[rs1]
rsp_rs2_data  out  DATA_WIDTH  value of x[rs2]
wb_valid  in  1  write-back request
wb_ready  out  1  write accepted on this edge when wb_valid is also high
wb_rd  in  ADDR_WIDTH  destination index
wb_data  in  DATA_WIDTH  write data
rf_we  out  1  to register file i_we
rf_addr  out  ADDR_WIDTH  to register file i_addr
rf_wdata  out  DATA_WIDTH  to register file i_data
rf_rdata  in  DATA_WIDTH  from register file o_data; valid the cycle after rf_addr is presented

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; rsp_valid=0; rsp_rs1_data=rsp_rs2_data=0; latched rs1/rs2=0; rf_we=0, rf_addr=0, rf_wdata=0 (combinational outputs derived from reset state).
- FSM states: IDLE, RD1, RD2, CAP2, RESP.
- IDLE:
  - wb_valid has priority: wb_ready=1, req_ready=0, rf_we=(wb_rd!=0), rf_addr=wb_rd, rf_wdata=wb_data; the write commits at the edge; stay in IDLE.
  - Otherwise req_ready=1; on req_valid, latch rs1/rs2 and go to RD1.
- RD1: rf_addr=rs1, rf_we=0 -> RD2.
- RD2: rf_addr=rs2; capture rf_rdata as rs1 data -> CAP2.
- CAP2: capture rf_rdata as rs2 data -> RESP.
- Latency: rsp_valid asserts exactly 3 cycles after the request-accept edge.
- wb_ready=0 and req_ready=0 in RD1, RD2 and CAP2. Write-back stalls while the port is busy reading.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - wb_ready=1; an accepted write drives the port and also updates held rsp_rs1_data/rsp_rs2_data if wb_rd matches rs1/rs2 and wb_rd!=0 (bypass keeps operands coherent).
  - On rsp_ready, go to IDLE (rsp_valid drops the next cycle). A write and rsp_ready in the same cycle are both honoured; the bypassed value is the one consumed only if it was already held, so the consumer sees the pre-write data that cycle.
- x0:
  - rs1==0 or rs2==0 forces the corresponding captured data to 0, whatever the register file returns.
  - Writes with wb_rd==0 are accepted (wb_ready=1) but rf_we stays 0.
- rs1==rs2: the address is read twice, with no special-casing.
- Reset mid-sequence: in-flight request abandoned; no rsp_valid pulse after reset.

Decomposition:
- Shared package (rv32i_pkg): ADDR_WIDTH/DATA_WIDTH defaults, REG_ZERO constant (5'd0), typedef enum for the FSM states.
- No sub-module; a single module is natural.

Test Plan:
- Write x5=0xDEADBEEF via wb_valid in IDLE, then request rs1=5, rs2=0 -> rsp_valid 3 cycles after accept, rs1_data=0xDEADBEEF, rs2_data=0.
- wb_valid and req_valid together in IDLE (wb_rd=3, data=0x11) -> write accepted first, req_ready=0 that cycle, request accepted next cycle; reading rs1=3 returns 0x11.
- wb_valid during RD1/RD2/CAP2 -> wb_ready=0, rf_we=0 until RESP, then the write commits.
- Hold rsp_ready=0 in RESP with rs1=7 and a write x7=0x55 -> rsp_rs1_data updates to 0x55; rsp_valid stays high; a subsequent rsp_ready returns to IDLE.
- Write x0=0xFFFFFFFF -> rf_we=0; a read of rs1=0 returns 0 even if the register-file model returns nonzero at address 0.
- Assert rst while in RD2 -> state returns to IDLE immediately; rsp_valid=0; the next request completes normally with correct data.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared widths, the x0 index and the operand-sequencer FSM states.
package rv32i_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int DATA_WIDTH = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef enum logic [2:0] {IDLE, RD1, RD2, CAP2, RESP} seq_state_t;
endpackage

// File: rtl/regfile_port_sequencer.sv
// regfile_port_sequencer: serialises rs1/rs2 reads and write-back writes onto one register-file port.
module regfile_port_sequencer #(
    parameter int ADDR_WIDTH = rv32i_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = rv32i_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_rs1,
    input  logic [ADDR_WIDTH-1:0] req_rs2,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rs1_data,
    output logic [DATA_WIDTH-1:0] rsp_rs2_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata
);
    import rv32i_pkg::*;
    localparam logic [ADDR_WIDTH-1:0] ZERO = ADDR_WIDTH'(REG_ZERO);
    seq_state_t state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] d1_q, d1_d, d2_q, d2_d;
    logic wb_hit;
    assign wb_hit = wb_valid && wb_rd != ZERO;
    assign rsp_rs1_data = d1_q;
    assign rsp_rs2_data = d2_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end
    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        req_ready = 1'b0;
        wb_ready  = 1'b0;
        rsp_valid = 1'b0;
        rf_we     = 1'b0;
        rf_addr   = '0;
        rf_wdata  = '0;
        case (state_q)
            IDLE: begin
                wb_ready  = 1'b1;
                req_ready = !wb_valid;
                if (wb_valid) begin
                    rf_we    = wb_hit;
                    rf_addr  = wb_rd;
                    rf_wdata = wb_data;
                end else if (req_valid) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = RD1;
                end
            end
            RD1: begin
                rf_addr = rs1_q;
                state_d = RD2;
            end
            // rf_rdata here is the rs1 read issued in RD1
            RD2: begin
                rf_addr = rs2_q;
                d1_d    = rs1_q == ZERO ? '0 : rf_rdata;
                state_d = CAP2;
            end
            CAP2: begin
                d2_d    = rs2_q == ZERO ? '0 : rf_rdata;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                wb_ready  = 1'b1;
                if (wb_valid) begin
                    rf_we    = wb_hit;
                    rf_addr  = wb_rd;
                    rf_wdata = wb_data;
                end
                // bypass keeps held operands coherent with the write just committed
                d1_d    = wb_hit && wb_rd == rs1_q ? wb_data : d1_q;
                d2_d    = wb_hit && wb_rd == rs2_q ? wb_data : d2_q;
                state_d = rsp_ready ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_regfile_port_sequencer.sv
// tb_regfile_port_sequencer: directed checks of the sequencer against a synchronous-read register-file model.
module tb_regfile_port_sequencer;
    logic clk = 1'b0, rst = 1'b1, mclr = 1'b1;
    logic req_valid = 1'b0, rsp_ready = 1'b0, wb_valid = 1'b0;
    logic [4:0] req_rs1 = '0, req_rs2 = '0, wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic req_ready, rsp_valid, wb_ready, rf_we;
    logic [4:0] rf_addr;
    logic [31:0] rsp_rs1_data, rsp_rs2_data, rf_wdata, rf_rdata;
    logic [31:0] mem [32];
    int cmp = 0, errs = 0;

    always #5 clk = ~clk;

    regfile_port_sequencer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    // register file model; address 0 deliberately returns garbage
    always @(posedge clk) begin
        if (mclr) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            rf_rdata <= '0;
        end else begin
            if (rf_we) mem[rf_addr] <= rf_wdata;
            rf_rdata <= rf_addr == 5'd0 ? 32'hCAFEF00D : mem[rf_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [4:0] a, input logic [4:0] b);
        req_valid = 1'b1; req_rs1 = a; req_rs2 = b;
        #1 chk("req_ready_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        step(); step();
        mclr = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_addr", rf_addr, 0);
        chk("rst_rf_wdata", rf_wdata, 0);
        chk("rst_rs1_data", rsp_rs1_data, 0);
        chk("rst_rs2_data", rsp_rs2_data, 0);
        rst = 1'b0;
        step();
        // write x5 then read rs1=5, rs2=0
        wb_valid = 1'b1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        #1;
        chk("wb_idle_we", rf_we, 1);
        chk("wb_idle_addr", rf_addr, 5);
        chk("wb_idle_wdata", rf_wdata, 32'hDEADBEEF);
        chk("wb_idle_ready", wb_ready, 1);
        chk("wb_idle_req_ready", req_ready, 0);
        step();
        wb_valid = 1'b0;
        req(5, 0);
        #1;
        chk("rd1_addr", rf_addr, 5);
        chk("rd1_we", rf_we, 0);
        chk("rd1_req_ready", req_ready, 0);
        chk("rd1_rsp_valid", rsp_valid, 0);
        step();
        chk("rd2_addr", rf_addr, 0);
        chk("rd2_rsp_valid", rsp_valid, 0);
        step();
        chk("cap2_rsp_valid", rsp_valid, 0);
        step();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rs1", rsp_rs1_data, 32'hDEADBEEF);
        chk("t1_rs2_x0", rsp_rs2_data, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1 chk("t1_rsp_drop", rsp_valid, 0);
        // write-back and request together: write wins
        wb_valid = 1'b1; wb_rd = 3; wb_data = 32'h11;
        req_valid = 1'b1; req_rs1 = 3; req_rs2 = 5;
        #1;
        chk("t2_req_ready_blocked", req_ready, 0);
        chk("t2_we", rf_we, 1);
        step();
        wb_valid = 1'b0;
        req(3, 5);
        step(); step(); step();
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rs1", rsp_rs1_data, 32'h11);
        chk("t2_rs2", rsp_rs2_data, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        // write-back stalls during the read sequence; rs1==rs2
        req(3, 3);
        wb_valid = 1'b1; wb_rd = 9; wb_data = 32'h99;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_busy_wb_ready", wb_ready, 0);
            chk("t3_busy_we", rf_we, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_resp_wb_ready", wb_ready, 1);
        chk("t3_resp_we", rf_we, 1);
        chk("t3_resp_addr", rf_addr, 9);
        chk("t3_rs1", rsp_rs1_data, 32'h11);
        chk("t3_rs2", rsp_rs2_data, 32'h11);
        step();
        wb_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("t3_rsp_drop", rsp_valid, 0);
        chk("t3_mem9", mem[9], 32'h99);
        // bypass while holding the response
        req(7, 9);
        step(); step(); step();
        chk("t4_rs1_pre", rsp_rs1_data, 0);
        chk("t4_rs2_pre", rsp_rs2_data, 32'h99);
        wb_valid = 1'b1; wb_rd = 7; wb_data = 32'h55;
        step();
        wb_valid = 1'b0;
        #1;
        chk("t4_hold_valid", rsp_valid, 1);
        chk("t4_bypass_rs1", rsp_rs1_data, 32'h55);
        chk("t4_rs2_kept", rsp_rs2_data, 32'h99);
        wb_valid = 1'b1; wb_rd = 9; wb_data = 32'hAA; rsp_ready = 1'b1;
        #1 chk("t4_same_cycle_rs2", rsp_rs2_data, 32'h99);
        step();
        wb_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("t4_rsp_drop", rsp_valid, 0);
        chk("t4_mem9", mem[9], 32'hAA);
        // x0 writes are dropped, x0 reads are zero
        wb_valid = 1'b1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
        #1;
        chk("t5_x0_we", rf_we, 0);
        chk("t5_x0_wb_ready", wb_ready, 1);
        step();
        wb_valid = 1'b0;
        req(0, 7);
        step(); step(); step();
        chk("t5_rs1_x0", rsp_rs1_data, 0);
        chk("t5_rs2", rsp_rs2_data, 32'h55);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        // reset in RD2 abandons the request
        req(9, 5);
        #1 chk("t6_rd1_addr", rf_addr, 9);
        step();
        rst = 1'b1;
        #1;
        chk("t6_rst_rsp_valid", rsp_valid, 0);
        chk("t6_rst_addr", rf_addr, 0);
        chk("t6_rst_req_ready", req_ready, 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t6_no_rsp_after_rst", rsp_valid, 0);
            step();
        end
        req(9, 5);
        step(); step();
        #1 chk("t6_not_early", rsp_valid, 0);
        step();
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rs1", rsp_rs1_data, 32'hAA);
        chk("t6_rs2", rsp_rs2_data, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
